// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file and its pending-write scoreboard.
package regfile_pkg;

    typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: set on issue, cleared on writeback or by the clear sequencer.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = 2,
    parameter int AW    = rf_aw(RF_NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [AW-1:0]     set_idx,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_idx,
    input  logic              wipe_en,
    input  logic [AW-1:0]     wipe_idx,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    pend_out
);

    logic [NREGS-1:0] pend;

    // A new producer issuing in the same cycle as the old one retires keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (set_en && set_idx == AW'(i)) begin
                    pend[i] <= 1'b1;
                end else if ((clr_en && clr_idx == AW'(i)) || (wipe_en && wipe_idx == AW'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_lookup
        assign pend_out[p] = pend[ra[p*AW +: AW]];
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one write port, optional
// write-to-read bypass, pending-write scoreboard and a sequenced one-register-per-cycle clear.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_pend,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                clr_req,
    output logic                clr_busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t     state, stateNext;
    logic [AW-1:0] idx, idxNext;
    logic [XLEN-1:0] regs [NREGS];

    logic idle;
    logic writeOk;
    logic issueOk;

    assign idle    = (state == RF_IDLE);
    assign writeOk = idle && we && (wa != '0);
    assign issueOk = idle && iss_valid && (iss_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_IDLE;
            idx   <= '0;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
        end
    end

    // The clear walks x1..x(NREGS-1) and returns to IDLE on the cycle that wipes the last one.
    always_comb begin
        stateNext = state;
        idxNext   = idx;
        clr_busy  = 1'b0;
        case (state)
            RF_IDLE: begin
                if (clr_req) begin
                    stateNext = RF_CLEAR;
                    idxNext   = AW'(1);
                end
            end
            RF_CLEAR: begin
                clr_busy = 1'b1;
                if (idx == LAST_IDX) begin
                    stateNext = RF_IDLE;
                    idxNext   = '0;
                end else begin
                    idxNext = idx + AW'(1);
                end
            end
            default: begin
                stateNext = RF_IDLE;
                idxNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == RF_CLEAR) begin
            regs[idx] <= '0;
        end else if (writeOk) begin
            regs[wa] <= wd;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_read
        logic [AW-1:0] addr;
        assign addr = ra[p*AW +: AW];
        assign rd[p*XLEN +: XLEN] = ((BYPASS != 0) && writeOk && (wa == addr)) ? wd :
                                    ((addr == '0) ? '0 : regs[addr]);
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issueOk),
        .set_idx  (iss_rd),
        .clr_en   (idle && we),
        .clr_idx  (wa),
        .wipe_en  (state == RF_CLEAR),
        .wipe_idx (idx),
        .ra       (ra),
        .pend_out (rd_pend)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NRD*AW-1:0]   ra = '0;
    logic [NRD*XLEN-1:0] rd, rdNb;
    logic [NRD-1:0]      rdPend, rdPendNb;
    logic                we = 1'b0;
    logic [AW-1:0]       wa = '0;
    logic [XLEN-1:0]     wd = '0;
    logic                issValid = 1'b0;
    logic [AW-1:0]       issRd = '0;
    logic                clrReq = 1'b0;
    logic                clrBusy, clrBusyNb;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_pend(rdPend),
        .we(we), .wa(wa), .wd(wd), .iss_valid(issValid), .iss_rd(issRd),
        .clr_req(clrReq), .clr_busy(clrBusy)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dutNb (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rdNb), .rd_pend(rdPendNb),
        .we(we), .wa(wa), .wd(wd), .iss_valid(issValid), .iss_rd(issRd),
        .clr_req(clrReq), .clr_busy(clrBusyNb)
    );

    typedef struct {
        string           tag;
        logic [XLEN-1:0] val;
    } expEntry_t;

    expEntry_t expQ[$];
    int compared   = 0;
    int mismatched = 0;

    logic [XLEN-1:0] mRegs [NREGS];
    logic            mPend [NREGS];
    logic            mBusy;
    int              mIdx;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < NREGS; i++) begin
            mRegs[i] = '0;
            mPend[i] = 1'b0;
        end
        mBusy = 1'b0;
        mIdx  = 0;
    endfunction

    function automatic logic [XLEN-1:0] expRead(input int p, input bit byp);
        logic [AW-1:0] a;
        a = ra[p*AW +: AW];
        if (byp && we && !mBusy && wa != '0 && wa == a) return wd;
        if (a == '0) return '0;
        return mRegs[a];
    endfunction

    function automatic logic [XLEN-1:0] expPend(input int p);
        logic [AW-1:0] a;
        a = ra[p*AW +: AW];
        return XLEN'(mPend[a]);
    endfunction

    // Reference behaviour of one rising edge, using the inputs held across it.
    function automatic void modelClock();
        if (mBusy) begin
            mRegs[mIdx] = '0;
            mPend[mIdx] = 1'b0;
            if (mIdx == NREGS - 1) mBusy = 1'b0;
            mIdx++;
        end else begin
            if (we && wa != '0) mRegs[wa] = wd;
            if (we) mPend[wa] = 1'b0;
            if (issValid && issRd != '0) mPend[issRd] = 1'b1;
            if (clrReq) begin
                mBusy = 1'b1;
                mIdx  = 1;
            end
        end
    endfunction

    function automatic void pushExpected();
        expQ.push_back('{"rd0",    expRead(0, 1'b1)});
        expQ.push_back('{"rd1",    expRead(1, 1'b1)});
        expQ.push_back('{"pend0",  expPend(0)});
        expQ.push_back('{"pend1",  expPend(1)});
        expQ.push_back('{"busy",   XLEN'(mBusy)});
        expQ.push_back('{"rdNb0",  expRead(0, 1'b0)});
        expQ.push_back('{"rdNb1",  expRead(1, 1'b0)});
        expQ.push_back('{"busyNb", XLEN'(mBusy)});
    endfunction

    task automatic sampleOutputs();
        logic [XLEN-1:0] obs [8];
        expEntry_t e;
        obs[0] = rd[0 +: XLEN];
        obs[1] = rd[XLEN +: XLEN];
        obs[2] = XLEN'(rdPend[0]);
        obs[3] = XLEN'(rdPend[1]);
        obs[4] = XLEN'(clrBusy);
        obs[5] = rdNb[0 +: XLEN];
        obs[6] = rdNb[XLEN +: XLEN];
        obs[7] = XLEN'(clrBusyNb);
        for (int i = 0; i < 8; i++) begin
            e = expQ.pop_front();
            checkOutput(e.tag, obs[i], e.val);
        end
    endtask

    // One clock cycle: drive, predict, sample at negedge, then advance model and DUT together.
    task automatic applyStimulus(input int ra0, input int ra1, input bit weIn, input int waIn,
                                 input logic [XLEN-1:0] wdIn, input bit issIn, input int issRdIn,
                                 input bit clrIn);
        ra       = {AW'(ra1), AW'(ra0)};
        we       = weIn;
        wa       = AW'(waIn);
        wd       = wdIn;
        issValid = issIn;
        issRd    = AW'(issRdIn);
        clrReq   = clrIn;
        pushExpected();
        @(negedge clk);
        sampleOutputs();
        @(posedge clk);
        modelClock();
        #1;
    endtask

    task automatic idleRead(input int ra0, input int ra1);
        applyStimulus(ra0, ra1, 1'b0, 0, '0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int a = 0; a < NREGS; a++) idleRead(a, NREGS - 1 - a);

        applyStimulus(5, 0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        idleRead(5, 5);

        applyStimulus(0, 0, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        idleRead(0, 0);

        applyStimulus(7, 0, 1'b0, 0, '0, 1'b1, 7, 1'b0);
        applyStimulus(7, 7, 1'b1, 7, 32'h0000_0777, 1'b1, 7, 1'b0);
        applyStimulus(7, 3, 1'b1, 7, 32'h0000_0007, 1'b0, 0, 1'b0);
        idleRead(7, 5);

        for (int a = 1; a < NREGS; a++)
            applyStimulus(a, $urandom_range(NREGS - 1), 1'b1, a, XLEN'(a), 1'b0, 0, 1'b0);
        applyStimulus(3, 9, 1'b0, 0, '0, 1'b1, 3, 1'b0);
        applyStimulus(3, 12, 1'b0, 0, '0, 1'b0, 0, 1'b1);
        for (int c = 0; c < NREGS - 1; c++) begin
            if (c == 4)       applyStimulus(9, 9, 1'b1, 9, 32'h1, 1'b0, 0, 1'b0);
            else if (c == 6)  applyStimulus(11, 3, 1'b0, 0, '0, 1'b1, 11, 1'b0);
            else if (c == 8)  applyStimulus(9, 20, 1'b0, 0, '0, 1'b0, 0, 1'b1);
            else              idleRead($urandom_range(NREGS - 1), $urandom_range(NREGS - 1));
        end
        for (int a = 0; a < NREGS; a++) idleRead(a, NREGS - 1 - a);

        for (int a = 1; a < 16; a++)
            applyStimulus(a, 0, 1'b1, a, 32'hA500_0000 | XLEN'(a), a == 4, 12, 1'b0);
        applyStimulus(2, 12, 1'b0, 0, '0, 1'b0, 0, 1'b1);
        for (int c = 0; c < 10; c++) idleRead($urandom_range(NREGS - 1), 14);
        #2;
        rst_n = 1'b0;
        we = 1'b0; issValid = 1'b0; clrReq = 1'b0;
        modelReset();
        for (int a = 0; a < NREGS; a++) begin
            ra = {AW'(NREGS - 1 - a), AW'(a)};
            #1;
            pushExpected();
            sampleOutputs();
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(20, 21, 1'b1, 20, 32'h1234_5678, 1'b0, 0, 1'b0);
        applyStimulus(20, 0, 1'b0, 0, '0, 1'b0, 0, 1'b1);
        for (int c = 0; c < NREGS - 1; c++) idleRead(20, $urandom_range(NREGS - 1));
        idleRead(20, 1);
        idleRead(20, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
